demorgan_sweep: RTL and testbench
=================================

# demorgan_sweep

Parametrised self-checking stimulus engine for the De Morgan gate blocks. It sweeps every operand pair of a WIDTH-bit A/B bus in truth-table order and drives each pair into an external combinational DUT. It checks the DUT's NOR and NAND outputs against the De Morgan forms (~A & ~B, ~A | ~B) and reports a pass flag, a mismatch count and the first failing vector. It sits beside the gate under test as an on-chip replacement for the printed truth-table bench.

## Interface
- WIDTH, 1, operand width; N = 2^(2*WIDTH) vectors per sweep
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle request; honoured only in IDLE
- hold  in  1  pause; freezes the sweep while in RUN
- a  out  WIDTH  stimulus operand A, registered
- b  out  WIDTH  stimulus operand B, registered
- dut_nor  in  WIDTH  DUT response for ~(A|B), combinational from a/b
- dut_nand  in  WIDTH  DUT response for ~(A&B), combinational from a/b
- busy  out  1  high in RUN and FINISH
- done  out  1  one-cycle pulse at end of sweep
- pass  out  1  high when the sweep completed with err_count = 0; held until next start
- err_count  out  2*WIDTH+1  number of vectors with any mismatch; held until next start
- first_fail  out  2*WIDTH  index {a,b} of the first mismatching vector
- fail_mask  out  2  first failing vector: bit0 = NOR mismatch, bit1 = NAND mismatch

## Operation
- States: IDLE, RUN, FINISH. Reset → IDLE.
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_mask=0, idx=0.
- Vector index idx has 2*WIDTH bits. a = idx[2W-1:W], b = idx[W-1:0]. For WIDTH=1 the order is 00, 01, 10, 11.
- IDLE + start:
  - Clear idx, err_count, first_fail, fail_mask and pass.
  - Go to RUN.
- RUN, hold=0, one vector per edge:
  - Compute exp_nor = ~a & ~b and exp_nand = ~a | ~b, full width.
  - Set m0 = (dut_nor != exp_nor) and m1 = (dut_nand != exp_nand).
  - If m0|m1: increment err_count. If this is the first mismatch, capture first_fail = idx and fail_mask = {m1,m0}.
  - If idx = N-1, go to FINISH with idx held. Otherwise increment idx.
- RUN, hold=1: no compare, idx, a and b frozen, no counter change.
- FINISH: done=1 for exactly one cycle. pass = (err_count == 0), including a mismatch on the final vector. Then go to IDLE.
- start is ignored in RUN and FINISH. hold is ignored outside RUN.
- err_count never wraps, because its maximum value N fits in 2*WIDTH+1 bits.
- After done, a and b keep the last vector until the next start.

## Timing
- start sampled at edge k → busy=1 and a=b=0 after edge k.
- Vector i is compared at edge k+1+i (hold=0).
- done is high during the cycle after edge k+N and busy drops at edge k+N+1. Sweep latency from start to done is N+1 cycles, plus one cycle per held cycle.
- The DUT path from a/b to dut_nor/dut_nand must settle within one clk period.
- Reset asserted mid-sweep: all outputs take their reset values immediately (asynchronously). No done pulse is produced and the partial results are lost.
- start and reset released in the same cycle: reset wins. start is honoured only on an edge where reset is low.

## Configuration
- DEMORGAN_SWEEP_STOP_EN defined: the first mismatching vector ends the sweep.
  - RUN → FINISH at that edge, with err_count=1 and pass=0.
  - a/b stay at the failing vector.
  - Latency = failing index + 2 cycles to done.
- Not defined: the full N-vector sweep always runs and all mismatches are counted.

## Test plan
- WIDTH=1, ideal DUT, start pulse:
  - a/b step through 00, 01, 10, 11 on consecutive cycles.
  - done high 5 cycles after start; pass=1, err_count=0.
- WIDTH=2, DUT nand bit0 stuck at 0, macro undefined:
  - err_count=12, first_fail=0, fail_mask=2'b10, pass=0.
  - done 17 cycles after start.
- WIDTH=2, ideal DUT, hold high for 3 cycles at idx=7:
  - a=1, b=3 stable during the hold.
  - done 20 cycles after start; pass=1.
- WIDTH=2, reset pulsed while idx=5:
  - All outputs are 0 in the same cycle and no done pulse appears.
  - A following start completes a clean 17-cycle sweep.
- WIDTH=2, ideal DUT, start re-pulsed at idx=4 and during FINISH:
  - Both pulses are ignored, done still occurs 17 cycles after the first start, and the block returns to IDLE.
- DEMORGAN_SWEEP_STOP_EN defined, WIDTH=2, DUT nor bit1 inverted only at idx=6:
  - done 8 cycles after start.
  - err_count=1, first_fail=6, a=1, b=2, fail_mask=2'b01, pass=0.

Source files
------------

// File: rtl/demorgan_sweep.sv
// Self-checking stimulus engine: sweeps every {a,b} pair and checks an external NOR/NAND DUT against De Morgan forms.
// Optional build macro DEMORGAN_SWEEP_STOP_EN: end the sweep at the first mismatching vector.
module demorgan_sweep #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               hold,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   dut_nor,
  input  logic [WIDTH-1:0]   dut_nand,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [2*WIDTH-1:0] first_fail,
  output logic [1:0]         fail_mask
);

  localparam int IW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW:0]     err_q, err_d;
  logic [IW-1:0]   first_fail_q, first_fail_d;
  logic [1:0]      fail_mask_q, fail_mask_d;
  logic            pass_q, pass_d;

  logic [WIDTH-1:0] exp_nor, exp_nand;
  logic             m0, m1, last_step;

  // Stimulus comes straight from the index register, so a/b are registered outputs.
  assign a = idx_q[IW-1:WIDTH];
  assign b = idx_q[WIDTH-1:0];

  assign exp_nor  = ~a & ~b;
  assign exp_nand = ~a | ~b;
  assign m0       = (dut_nor  != exp_nor);
  assign m1       = (dut_nand != exp_nand);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    err_d        = err_q;
    first_fail_d = first_fail_q;
    fail_mask_d  = fail_mask_q;
    pass_d       = pass_q;
    last_step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d        = '0;
          err_d        = '0;
          first_fail_d = '0;
          fail_mask_d  = '0;
          pass_d       = 1'b0;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (!hold) begin
          if (m0 || m1) begin
            err_d = err_q + 1'b1;
            // An empty count means this is the first failing vector of the sweep.
            if (err_q == '0) begin
              first_fail_d = idx_q;
              fail_mask_d  = {m1, m0};
            end
          end
`ifdef DEMORGAN_SWEEP_STOP_EN
          last_step = (idx_q == LAST_IDX) || m0 || m1;
`else
          last_step = (idx_q == LAST_IDX);
`endif
          if (last_step) begin
            state_d = FINISH;
            pass_d  = (err_d == '0);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      err_q        <= '0;
      first_fail_q <= '0;
      fail_mask_q  <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      first_fail_q <= first_fail_d;
      fail_mask_q  <= fail_mask_d;
      pass_q       <= pass_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = first_fail_q;
  assign fail_mask  = fail_mask_q;

endmodule

// File: tb/tb_demorgan_sweep.sv
// Directed bench for demorgan_sweep: a WIDTH=1 instance with an ideal DUT and a WIDTH=2 instance with selectable faults.
module tb_demorgan_sweep;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  // WIDTH=1 instance
  logic       start1, hold1;
  logic [0:0] a1, b1, nor1, nand1;
  logic       busy1, done1, pass1;
  logic [2:0] err1;
  logic [1:0] ff1, mask1;

  // WIDTH=2 instance
  logic       start2, hold2;
  logic [1:0] a2, b2, nor2, nand2;
  logic       busy2, done2, pass2;
  logic [4:0] err2;
  logic [3:0] ff2;
  logic [1:0] mask2;
  int         fault;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign nor1  = ~(a1 | b1);
  assign nand1 = ~(a1 & b1);

  // fault 1: nand bit0 stuck at 0; fault 2: nor bit1 inverted only at vector 6
  assign nor2  = ~(a2 | b2) ^ ((fault == 2 && {a2, b2} == 4'd6) ? 2'b10 : 2'b00);
  assign nand2 = (fault == 1) ? (~(a2 & b2) & 2'b10) : ~(a2 & b2);

  demorgan_sweep #(.WIDTH(1)) u_w1 (
    .clk(clk), .reset(reset), .start(start1), .hold(hold1),
    .a(a1), .b(b1), .dut_nor(nor1), .dut_nand(nand1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail(ff1), .fail_mask(mask1)
  );

  demorgan_sweep #(.WIDTH(2)) u_w2 (
    .clk(clk), .reset(reset), .start(start2), .hold(hold2),
    .a(a2), .b(b2), .dut_nor(nor2), .dut_nand(nand2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail(ff2), .fail_mask(mask2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-12s got=%0d", tag, got);
    end else begin
      $display("FAIL %-12s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Pulses start2 and counts edges (the start-sampling edge is 1) until done2 is seen.
  task automatic run2(input int hold_idx, input int hold_len, input bit restart, output int cyc);
    int  held;
    bit  fin;
    held = 0;
    fin  = 1'b0;
    cyc  = 0;
    @(negedge clk);
    start2 = 1'b1;
    for (int i = 0; i < 100 && !fin; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      start2 = 1'b0;
      if (done2) begin
        fin = 1'b1;
      end else begin
        if (hold2) begin
          check("hold_ab", {28'd0, a2, b2}, hold_idx);
          held++;
          if (held == hold_len) hold2 = 1'b0;
        end else if (hold_len > 0 && held == 0 && {a2, b2} == hold_idx[3:0]) begin
          hold2 = 1'b1;
        end
        if (restart && {a2, b2} == 4'd4) start2 = 1'b1;
      end
    end
    if (!fin) begin
      check("timeout", 0, 1);
      cyc = -1;
    end
  endtask

  initial begin
    int  cyc;
    bit  seen_done;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    start1   = 1'b0;
    hold1    = 1'b0;
    start2   = 1'b0;
    hold2    = 1'b0;
    fault    = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy2, 0);
    check("rst_done", done2, 0);
    check("rst_ab", {a2, b2}, 0);
    check("rst_err", err2, 0);
    @(negedge clk);
    reset = 1'b0;

    // WIDTH=1 ideal sweep: vectors 00,01,10,11 then done on the 5th edge
    @(negedge clk);
    start1 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      start1 = 1'b0;
      check("w1_ab", {a1, b1}, c - 1);
      check("w1_busy", busy1, 1);
    end
    @(posedge clk);
    #1;
    check("w1_done5", done1, 1);
    check("w1_pass", pass1, 1);
    check("w1_err", err1, 0);
    @(posedge clk);
    #1;
    check("w1_busy_off", busy1, 0);
    check("w1_done_off", done1, 0);

    // WIDTH=2 ideal sweep with a 3-cycle hold at idx=7
    run2(7, 3, 1'b0, cyc);
    check("hold_lat", cyc, 20);
    check("hold_pass", pass2, 1);
    check("hold_err", err2, 0);
    hold2 = 1'b0;
    @(posedge clk);
    #1;

`ifdef DEMORGAN_SWEEP_STOP_EN
    // Stop-on-first-failure: nor bit1 flipped at vector 6 only
    fault = 2;
    run2(0, 0, 1'b0, cyc);
    check("stop_lat", cyc, 8);
    check("stop_err", err2, 1);
    check("stop_ff", ff2, 6);
    check("stop_ab", {a2, b2}, 6);
    check("stop_mask", mask2, 1);
    check("stop_pass", pass2, 0);
`else
    // Full sweep with nand bit0 stuck low: 12 of 16 vectors mismatch
    fault = 1;
    run2(0, 0, 1'b0, cyc);
    check("stuck_lat", cyc, 17);
    check("stuck_err", err2, 12);
    check("stuck_ff", ff2, 0);
    check("stuck_mask", mask2, 2);
    check("stuck_pass", pass2, 0);
`endif
    fault = 0;
    @(posedge clk);
    #1;

    // Reset mid-sweep at idx=5: outputs clear asynchronously, no done follows
    @(negedge clk);
    start2 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      start2 = 1'b0;
      if ({a2, b2} == 4'd5) break;
    end
    check("pre_rst_ab", {a2, b2}, 5);
    #2;
    reset = 1'b1;
    #1;
    check("arst_ab", {a2, b2}, 0);
    check("arst_busy", busy2, 0);
    check("arst_err", err2, 0);
    check("arst_pass", pass2, 0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done2 || busy2) seen_done = 1'b1;
    end
    check("no_done", seen_done, 0);
    run2(0, 0, 1'b0, cyc);
    check("post_rst_lat", cyc, 17);
    check("post_rst_pass", pass2, 1);

    // start re-pulsed at idx=4 and during FINISH: both ignored
    @(posedge clk);
    #1;
    run2(0, 0, 1'b1, cyc);
    check("restart_lat", cyc, 17);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    check("fin_idle", busy2, 0);
    check("fin_done1", done2, 0);
    check("fin_ab", {a2, b2}, 15);
    @(posedge clk);
    #1;
    check("fin_stay", busy2, 0);
    check("fin_pass", pass2, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
